// File: rtl/rv32i_types.sv
// Shared types and widths for the retirement stage: FSM state, ROB head view, register index widths.
package rv32i_types;

  localparam int ARCH_REG_BITS  = 5;
  localparam int PHYS_REG_BITS  = 6;
  localparam int ROB_ADDR_WIDTH = 4;
  localparam int NUM_ARCH_REGS  = 1 << ARCH_REG_BITS;

  localparam logic [ARCH_REG_BITS-1:0] FIRST_RESTORE_REG = ARCH_REG_BITS'(1);
  localparam logic [ARCH_REG_BITS-1:0] LAST_RESTORE_REG  = ARCH_REG_BITS'(NUM_ARCH_REGS - 1);

  typedef enum logic [1:0] {
    COMMIT,
    STORE_WAIT,
    RESTORE
  } commit_state_t;

  typedef struct packed {
    logic [ARCH_REG_BITS-1:0]  rd;
    logic [PHYS_REG_BITS-1:0]  pd;
    logic                      is_store;
    logic                      mispredict;
    logic [31:0]               target;
    logic [ROB_ADDR_WIDTH-1:0] idx;
  } rob_head_t;

endpackage

// File: rtl/retire_rat.sv
// Retirement RAT: 32 architectural-to-physical mappings, identity after reset,
// one write port (commit) and two combinational read ports (commit lookup, restore lookup).
module retire_rat
  import rv32i_types::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ARCH_REG_BITS-1:0] waddr,
  input  logic [PHYS_REG_BITS-1:0] wdata,
  input  logic [ARCH_REG_BITS-1:0] cmt_raddr,
  output logic [PHYS_REG_BITS-1:0] cmt_rdata,
  input  logic [ARCH_REG_BITS-1:0] rst_raddr,
  output logic [PHYS_REG_BITS-1:0] rst_rdata
);

  logic [PHYS_REG_BITS-1:0] rat_q [NUM_ARCH_REGS];
  logic [PHYS_REG_BITS-1:0] rat_d [NUM_ARCH_REGS];

  always_comb begin
    rat_d = rat_q;
    if (we) rat_d[waddr] = wdata;
  end

  // NOTE: this array is reset on purpose -- the identity mapping is architectural state,
  // so it cannot be left to a RAM macro without reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) rat_q[i] <= PHYS_REG_BITS'(i);
    end else begin
      rat_q <= rat_d;
    end
  end

  assign cmt_rdata = rat_q[cmt_raddr];
  assign rst_rdata = rat_q[rst_raddr];

endmodule

// File: rtl/retire_commit.sv
// In-order retirement: pops the ROB head, frees superseded phys regs, releases stores,
// and on a mispredict flushes and replays the RRAT into the front-end RAT. Option: COMMIT_ORDER_EN.
module retire_commit
  import rv32i_types::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rob_head_valid,
  input  logic                      rob_head_ready,
  input  logic [ARCH_REG_BITS-1:0]  rob_head_rd,
  input  logic [PHYS_REG_BITS-1:0]  rob_head_pd,
  input  logic                      rob_head_is_store,
  input  logic                      rob_head_mispredict,
  input  logic [31:0]               rob_head_target,
  input  logic [ROB_ADDR_WIDTH-1:0] rob_head_idx,
  input  logic                      mem_store_ack,
  output logic                      rob_dequeue,
  output logic                      free_list_enqueue,
  output logic [PHYS_REG_BITS-1:0]  free_list_phys,
  output logic                      store_commit,
  output logic                      flush,
  output logic [31:0]               flush_pc,
  output logic                      free_list_restore,
  output logic                      rat_restore_we,
  output logic [ARCH_REG_BITS-1:0]  rat_restore_idx,
  output logic [PHYS_REG_BITS-1:0]  rat_restore_phys,
  output logic                      rename_stall
`ifdef COMMIT_ORDER_EN
  ,
  output logic [63:0]               commit_order,
  output logic                      commit_valid
`endif
);

  rob_head_t                head;
  commit_state_t            state_q, state_d;
  logic [ARCH_REG_BITS-1:0] cnt_q, cnt_d;
  logic                     head_fire;
  logic                     rrat_we;
  logic [PHYS_REG_BITS-1:0] cmt_phys, rst_phys;

  assign head = '{rd: rob_head_rd, pd: rob_head_pd, is_store: rob_head_is_store,
                  mispredict: rob_head_mispredict, target: rob_head_target, idx: rob_head_idx};
  assign head_fire = rob_head_valid && rob_head_ready;

  retire_rat u_rrat (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (rrat_we),
    .waddr     (head.rd),
    .wdata     (head.pd),
    .cmt_raddr (head.rd),
    .cmt_rdata (cmt_phys),
    .rst_raddr (cnt_q),
    .rst_rdata (rst_phys)
  );

  // NOTE: sequential state uses <= so every flop samples pre-edge values; the comb blocks use =.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COMMIT;
      cnt_q   <= FIRST_RESTORE_REG;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      COMMIT: begin
        if (head_fire) begin
          if (head.is_store) begin
            state_d = STORE_WAIT;
          end else if (head.mispredict) begin
            state_d = RESTORE;
            cnt_d   = FIRST_RESTORE_REG;
          end
        end
      end
      STORE_WAIT: if (mem_store_ack) state_d = COMMIT;
      RESTORE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_RESTORE_REG) begin
          state_d = COMMIT;
          cnt_d   = FIRST_RESTORE_REG;
        end
      end
      default: state_d = COMMIT;
    endcase
  end

  always_comb begin
    rob_dequeue       = 1'b0;
    free_list_enqueue = 1'b0;
    free_list_phys    = '0;
    store_commit      = 1'b0;
    flush             = 1'b0;
    flush_pc          = '0;
    free_list_restore = 1'b0;
    rat_restore_we    = 1'b0;
    rat_restore_idx   = '0;
    rat_restore_phys  = '0;
    rename_stall      = 1'b0;
    rrat_we           = 1'b0;
    case (state_q)
      COMMIT: begin
        if (head_fire) begin
          if (head.is_store) begin
            store_commit = 1'b1;
          end else begin
            rob_dequeue = 1'b1;
            // x0 has no mapping to supersede, so it neither frees nor updates the RRAT.
            if (head.rd != '0) begin
              free_list_enqueue = 1'b1;
              free_list_phys    = cmt_phys;
              rrat_we           = 1'b1;
            end
            if (head.mispredict) begin
              flush             = 1'b1;
              flush_pc          = head.target;
              free_list_restore = 1'b1;
              rename_stall      = 1'b1;
            end
          end
        end
      end
      STORE_WAIT: rob_dequeue = mem_store_ack;
      RESTORE: begin
        rename_stall     = 1'b1;
        rat_restore_we   = 1'b1;
        rat_restore_idx  = cnt_q;
        rat_restore_phys = rst_phys;
      end
      default: ;
    endcase
  end

`ifdef COMMIT_ORDER_EN
  logic [63:0] commit_order_q, commit_order_d;

  assign commit_order_d = commit_order_q + {63'd0, rob_dequeue};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) commit_order_q <= '0;
    else        commit_order_q <= commit_order_d;
  end

  assign commit_order = commit_order_q;
  assign commit_valid = rob_dequeue;
`endif

  // The ROB must hold its head steady while a released store is outstanding.
  assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == STORE_WAIT) |-> $stable(head.idx));

endmodule
